// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared state encoding and mode constants for the Booth multiplier
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } booth_state_e;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth iteration: add/sub/none then arithmetic shift
module booth_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] acc_i,
    input  logic [WIDTH:0] q_i,
    input  logic           q_m1_i,
    input  logic [WIDTH:0] m_i,
    output logic [WIDTH:0] acc_o,
    output logic [WIDTH:0] q_o,
    output logic           q_m1_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc_i;
        case ({q_i[0], q_m1_i})
            2'b10:   sum = acc_i - m_i;
            2'b01:   sum = acc_i + m_i;
            default: sum = acc_i;
        endcase
        // Shift of {sum, q, q_m1} right by one, replicating the accumulator sign bit
        acc_o  = {sum[WIDTH], sum[WIDTH:1]};
        q_o    = {sum[0], q_i[WIDTH:1]};
        q_m1_o = q_i[0];
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - sequential radix-2 Booth multiplier, signed or unsigned, WIDTH+1 steps
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int             CW       = $clog2(WIDTH + 2);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH + 1);

    booth_state_e          state_q, state_d;
    logic [WIDTH:0]        acc_q, acc_d;
    logic [WIDTH:0]        q_q, q_d;
    logic                  qm1_q, qm1_d;
    logic [WIDTH:0]        m_q, m_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0]    product_q, product_d;

    logic [WIDTH:0]        acc_step;
    logic [WIDTH:0]        q_step;
    logic                  qm1_step;
    logic                  a_sign;
    logic                  b_sign;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_i  (acc_q),
        .q_i    (q_q),
        .q_m1_i (qm1_q),
        .m_i    (m_q),
        .acc_o  (acc_step),
        .q_o    (q_step),
        .q_m1_o (qm1_step)
    );

    // One extra operand bit keeps the most-negative signed value and full unsigned range exact
    assign a_sign = (signed_mode == MODE_UNSIGNED) ? 1'b0 : a[WIDTH-1];
    assign b_sign = (signed_mode == MODE_UNSIGNED) ? 1'b0 : b[WIDTH-1];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    q_d     = {a_sign, a};
                    m_d     = {b_sign, b};
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q != '0) begin
                    acc_d = acc_step;
                    q_d   = q_step;
                    qm1_d = qm1_step;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // The top two bits of {acc,q} are pure sign extension of the 2*WIDTH result
                    product_d = {acc_q[WIDTH-2:0], q_q};
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule
